sample_serializer: RTL and testbench

- Consumer end of the phase-accumulator data handshake. Requests samples with a one-cycle `next_data_strobe_o` pulse and captures the word returned with `data_in_valid_strobe_i`.
- Shifts each captured word out MSB-first on a serial link with bit clock and frame sync. This is how CORDIC/counter samples leave the chip on few pins.

---
 rtl/sample_serializer.sv | 99 +++++++++
 tb/tb_sample_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sample_serializer.sv
// Requests samples from the producer and shifts each one out MSB-first with bit clock and frame sync.
// Optional trailing even-parity bit when SAMPLE_SERIALIZER_PARITY_EN is defined.
module sample_serializer #(
   parameter int N_FRAC  = 7,
   parameter int CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [N_FRAC:0]   data_i,
   input  logic              data_in_valid_strobe_i,
   output logic              next_data_strobe_o,
   output logic              ser_data_o,
   output logic              ser_clk_o,
   output logic              ser_frame_o,
   output logic              busy_o
);

   localparam int W = N_FRAC + 1;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(NB + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;

   state_t          state, state_n;
   logic [NB-1:0]   sh, sh_n, load;
   logic [DW-1:0]   div, div_n;
   logic [BW-1:0]   cnt, cnt_n;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
   assign load = {data_i, ^data_i};
`else
   assign load = data_i;
`endif

   always_comb begin
      state_n = state;
      sh_n    = sh;
      div_n   = div;
      cnt_n   = cnt;
      case (state)
         IDLE:  if (enable_i) state_n = REQ;
         REQ:   state_n = WAIT;
         WAIT: begin
            // A returning sample takes priority over a dropped enable.
            if (data_in_valid_strobe_i) begin
               sh_n    = load;
               div_n   = '0;
               cnt_n   = '0;
               state_n = SHIFT;
            end else if (!enable_i) begin
               state_n = IDLE;
            end
         end
         SHIFT: begin
            if (div == DW'(CLK_DIV - 1)) begin
               div_n = '0;
               sh_n  = sh << 1;
               cnt_n = cnt + BW'(1);
               if (cnt == BW'(NB - 1)) state_n = enable_i ? REQ : IDLE;
            end else begin
               div_n = div + DW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= IDLE;
         sh                 <= '0;
         div                <= '0;
         cnt                <= '0;
         next_data_strobe_o <= 1'b0;
         ser_data_o         <= 1'b0;
         ser_clk_o          <= 1'b0;
         ser_frame_o        <= 1'b0;
         busy_o             <= 1'b0;
      end else begin
         state              <= state_n;
         sh                 <= sh_n;
         div                <= div_n;
         cnt                <= cnt_n;
         next_data_strobe_o <= (state_n == REQ);
         ser_data_o         <= (state_n == SHIFT) && sh_n[NB-1];
         ser_clk_o          <= (state_n == SHIFT) && (div_n >= DW'(CLK_DIV / 2));
         ser_frame_o        <= (state_n == SHIFT) && (cnt_n == '0);
         busy_o             <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_sample_serializer.sv
// Randomized bench for sample_serializer; expected serial waveforms are computed per word from its bits.
module tb_sample_serializer;

   localparam int N_FRAC  = 7;
   localparam int CLK_DIV = 4;
   localparam int W       = N_FRAC + 1;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   localparam int NT = NB * CLK_DIV;

   logic          clk = 1'b0;
   logic          rst, enable, valid;
   logic [W-1:0]  data;
   logic          strobe, ser_data, ser_clk, ser_frame, busy;
   logic [4:0]    obs;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sample_serializer #(.N_FRAC(N_FRAC), .CLK_DIV(CLK_DIV)) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .enable_i               (enable),
      .data_i                 (data),
      .data_in_valid_strobe_i (valid),
      .next_data_strobe_o     (strobe),
      .ser_data_o             (ser_data),
      .ser_clk_o              (ser_clk),
      .ser_frame_o            (ser_frame),
      .busy_o                 (busy)
   );

   // {busy, strobe, frame, clk, data}
   assign obs = {busy, strobe, ser_frame, ser_clk, ser_data};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [4:0] exp_shift(input logic [W-1:0] w, input int t);
      logic [NB-1:0] bits;
      int b, d;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
      bits = {w, ^w};
`else
      bits = w;
`endif
      b = t / CLK_DIV;
      d = t % CLK_DIV;
      return {1'b1, 1'b0, (b == 0), (d >= CLK_DIV / 2), bits[NB-1-b]};
   endfunction

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, obs, 5'b00000);
         valid = 1'($urandom_range(0, 1));
         data  = W'($urandom);
         tick();
      end
      valid = 1'b0;
   endtask

   task automatic expect_req(input string tag);
      check(tag, obs, 5'b11000);
      tick();
   endtask

   // Entered on the first WAIT cycle. drop_t=-2 drops enable together with valid.
   task automatic serve(input logic [W-1:0] w, input int delay, input int spur_t,
                        input int drop_t, input int rst_t);
      for (int i = 0; i < delay; i++) begin
         check("wait", obs, 5'b10000);
         tick();
      end
      check("wait", obs, 5'b10000);
      valid = 1'b1;
      data  = w;
      if (drop_t == -2) enable = 1'b0;
      tick();
      valid = 1'b0;
      data  = W'($urandom);
      for (int t = 0; t < NT; t++) begin
         if (t == rst_t) begin
            rst = 1'b1;
            tick();
            check("rst_mid", obs, 5'b00000);
            rst    = 1'b0;
            enable = 1'b0;
            return;
         end
         check("shift", obs, exp_shift(w, t));
         valid = (t == spur_t);
         if (t == spur_t) data = ~w;
         if (t == drop_t) enable = 1'b0;
         tick();
      end
      valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] w;
      rst    = 1'b1;
      enable = 1'b0;
      valid  = 1'b0;
      data   = '0;
      tick();
      tick();
      check("reset", obs, 5'b00000);
      enable = 1'b1;
      valid  = 1'b1;
      tick();
      check("reset_en", obs, 5'b00000);
      rst    = 1'b0;
      enable = 1'b0;
      valid  = 1'b0;
      idle_check("idle_spur", 4);

      enable = 1'b1;
      tick();
      expect_req("req_first");
      serve(8'hA5, 0, -1, -1, -1);
      expect_req("req_b2b1");
      serve(8'h80, 2, -1, -1, -1);
      expect_req("req_b2b2");
      serve(8'h7F, 1, 5, -1, -1);
      expect_req("req_b2b3");
      serve(8'h07, 0, -1, -1, -1);
      expect_req("req_b2b4");

      for (int i = 0; i < 20; i++) begin
         w = W'($urandom);
         serve(w, int'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NT - 1)) : -1, -1, -1);
         expect_req("req_rand");
      end

      serve(W'($urandom), 1, -1, int'($urandom_range(0, NT - 1)), -1);
      idle_check("idle_drop_shift", 5);

      enable = 1'b1;
      tick();
      expect_req("req_after_drop");
      check("wait_drop", obs, 5'b10000);
      enable = 1'b0;
      tick();
      idle_check("idle_drop_wait", 4);

      enable = 1'b1;
      tick();
      expect_req("req_valid_drop");
      serve(8'h3C, 0, -1, -2, -1);
      idle_check("idle_valid_drop", 3);

      enable = 1'b1;
      tick();
      expect_req("req_rst");
      serve(8'hC3, 0, -1, -1, 3 * CLK_DIV + 1);
      idle_check("idle_after_rst", 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
